// File: rtl/rom_arb_pkg.sv
// Shared types and constants for the two-port ROM access arbiter.
package rom_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  typedef logic port_id_t;

  // Byte address to word index: 4-byte words.
  localparam int WORD_SHIFT = 2;

endpackage

// File: rtl/rom_arb_grant.sv
// Combinational one-hot grant between the two requesters.
// ROM_ARB_ROUND_ROBIN_EN: a contended grant goes to the port not granted last.
module rom_arb_grant
  import rom_arb_pkg::*;
(
  input  logic       v0,
  input  logic       v1,
`ifdef ROM_ARB_ROUND_ROBIN_EN
  input  port_id_t   last,
`endif
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
`ifdef ROM_ARB_ROUND_ROBIN_EN
    if (v0 && v1) grant = last ? 2'b01 : 2'b10;
    else          grant = {v1, v0};
`else
    if (v0)      grant = 2'b01;
    else if (v1) grant = 2'b10;
`endif
  end

endmodule

// File: rtl/rom_access_arbiter.sv
// Shares one combinational ROM between two valid/ready requesters: IDLE -> ACCESS -> RESP.
// ROM_ARB_ROUND_ROBIN_EN selects round-robin instead of fixed port-0 priority.
module rom_access_arbiter
  import rom_arb_pkg::*;
#(
  parameter int BIT_WIDTH = 32,
  parameter int DEPTH     = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req0_valid,
  input  logic [BIT_WIDTH-1:0] req0_addr,
  output logic                 req0_ready,
  output logic                 rsp0_valid,
  output logic [BIT_WIDTH-1:0] rsp0_data,
  output logic                 rsp0_err,
  input  logic                 req1_valid,
  input  logic [BIT_WIDTH-1:0] req1_addr,
  output logic                 req1_ready,
  output logic                 rsp1_valid,
  output logic [BIT_WIDTH-1:0] rsp1_data,
  output logic                 rsp1_err,
  output logic [BIT_WIDTH-1:0] rom_addr,
  input  logic [BIT_WIDTH-1:0] rom_data
);

  state_t               state, state_nx;
  logic [1:0]           grant;
  logic                 take;
  port_id_t             sel_id, id_q;
  logic [BIT_WIDTH-1:0] sel_addr, idx_q;
  logic                 sel_err, err_q;

`ifdef ROM_ARB_ROUND_ROBIN_EN
  port_id_t last_q;

  always_ff @(posedge clk or negedge reset)
    if (!reset)                     last_q <= 1'b1;
    else if (state == IDLE && take) last_q <= sel_id;

  rom_arb_grant u_grant (.v0(req0_valid), .v1(req1_valid), .last(last_q), .grant(grant));
`else
  rom_arb_grant u_grant (.v0(req0_valid), .v1(req1_valid), .grant(grant));
`endif

  assign take     = |grant;
  assign sel_id   = grant[1];
  assign sel_addr = sel_id ? req1_addr : req0_addr;
  assign sel_err  = (sel_addr[1:0] != 2'b00) ||
                    ((sel_addr >> WORD_SHIFT) >= BIT_WIDTH'(DEPTH));

  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else        state <= state_nx;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (take) state_nx = ACCESS;
      ACCESS:  state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Per-port response registers so each port's data/err only move on its own responses.
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      idx_q     <= '0;
      id_q      <= 1'b0;
      err_q     <= 1'b0;
      rsp0_data <= '0;
      rsp0_err  <= 1'b0;
      rsp1_data <= '0;
      rsp1_err  <= 1'b0;
    end else begin
      if (state == IDLE && take) begin
        idx_q <= sel_addr >> WORD_SHIFT;
        id_q  <= sel_id;
        err_q <= sel_err;
      end
      if (state == ACCESS) begin
        if (id_q) begin
          rsp1_data <= err_q ? '0 : rom_data;
          rsp1_err  <= err_q;
        end else begin
          rsp0_data <= err_q ? '0 : rom_data;
          rsp0_err  <= err_q;
        end
      end
    end

  // Ready is gated by reset so nothing is handshaken while reset is held.
  always_comb begin
    req0_ready = reset && (state == IDLE) && grant[0];
    req1_ready = reset && (state == IDLE) && grant[1];
    rsp0_valid = (state == RESP) && !id_q;
    rsp1_valid = (state == RESP) && id_q;
    rom_addr   = (state == ACCESS) ? idx_q : '0;
  end

endmodule

// File: tb/tb_rom_access_arbiter.sv
// Directed bench for rom_access_arbiter; expectations follow the selected arbitration build.
module tb_rom_access_arbiter;

  logic        clk, reset;
  logic        req0_valid, req0_ready, rsp0_valid, rsp0_err;
  logic        req1_valid, req1_ready, rsp1_valid, rsp1_err;
  logic [31:0] req0_addr, req1_addr, rsp0_data, rsp1_data, rom_addr, rom_data;
  logic [31:0] rom [32];
  int          tests, fails;

  rom_access_arbiter #(.BIT_WIDTH(32), .DEPTH(32)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_ready(req0_ready),
    .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data), .rsp0_err(rsp0_err),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_ready(req1_ready),
    .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data), .rsp1_err(rsp1_err),
    .rom_addr(rom_addr), .rom_data(rom_data)
  );

  assign rom_data = (rom_addr < 32) ? rom[rom_addr[4:0]] : 32'hBAD0BAD0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    cyc();
    reset = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0; req0_addr = '0; req1_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_err, rsp1_err} !== 6'b0 ||
        rsp0_data !== 32'h0 || rsp1_data !== 32'h0 || rom_addr !== 32'h0) begin
      fails++;
      $display("FAIL reset_outputs: rdy=%b%b vld=%b%b err=%b%b d0=%h d1=%h rom_addr=%h, required all 0",
               req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_err, rsp1_err, rsp0_data, rsp1_data, rom_addr);
    end
    reset = 1'b1;
  endtask

  task automatic test_basic_read();
    do_reset();
    req0_valid = 1'b1; req0_addr = 32'h8; #1;
    tests++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      fails++; $display("FAIL basic_ready: rdy0=%b rdy1=%b, required 1 0", req0_ready, req1_ready);
    end
    cyc(); req0_valid = 1'b0; #1;
    tests++;
    if (rom_addr !== 32'd2 || rsp0_valid !== 1'b0 || req0_ready !== 1'b0) begin
      fails++; $display("FAIL basic_access: rom_addr=%0d vld0=%b rdy0=%b, required 2 0 0", rom_addr, rsp0_valid, req0_ready);
    end
    cyc(); #1;
    tests++;
    if (rsp0_valid !== 1'b1 || rsp0_data !== 32'hDEADBEEF || rsp0_err !== 1'b0 || rom_addr !== 32'h0 || rsp1_valid !== 1'b0) begin
      fails++; $display("FAIL basic_resp: vld0=%b data=%h err=%b rom_addr=%h vld1=%b, required 1 deadbeef 0 0 0",
                        rsp0_valid, rsp0_data, rsp0_err, rom_addr, rsp1_valid);
    end
    cyc(); #1;
    tests++;
    if (rsp0_valid !== 1'b0 || rsp0_data !== 32'hDEADBEEF || rom_addr !== 32'h0) begin
      fails++; $display("FAIL basic_hold: vld0=%b data=%h rom_addr=%h, required 0 deadbeef 0", rsp0_valid, rsp0_data, rom_addr);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0]  exp_rdy, exp_rsp;
    logic [31:0] exp_data;
    logic        turn;
    do_reset();
    req0_valid = 1'b1; req0_addr = 32'h0;
    req1_valid = 1'b1; req1_addr = 32'h4;
    for (int c = 0; c < 12; c++) begin
      #1;
`ifdef ROM_ARB_ROUND_ROBIN_EN
      turn = ((c / 3) % 2) == 1;
`else
      turn = 1'b0;
`endif
      exp_rdy  = (c % 3 == 0) ? (turn ? 2'b10 : 2'b01) : 2'b00;
      exp_rsp  = (c % 3 == 2) ? (turn ? 2'b10 : 2'b01) : 2'b00;
      exp_data = turn ? 32'h22221111 : 32'h11110000;
      tests++;
      if ({req1_ready, req0_ready} !== exp_rdy) begin
        fails++; $display("FAIL b2b_ready c=%0d: got %b, required %b", c, {req1_ready, req0_ready}, exp_rdy);
      end
      tests++;
      if ({rsp1_valid, rsp0_valid} !== exp_rsp) begin
        fails++; $display("FAIL b2b_rsp_valid c=%0d: got %b, required %b", c, {rsp1_valid, rsp0_valid}, exp_rsp);
      end
      if (exp_rsp != 2'b00) begin
        tests++;
        if ((turn ? rsp1_data : rsp0_data) !== exp_data) begin
          fails++; $display("FAIL b2b_data c=%0d: got %h, required %h", c, turn ? rsp1_data : rsp0_data, exp_data);
        end
      end
      cyc();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic test_addr_errors();
    logic [31:0] addrs [2];
    logic [31:0] idx [2];
    addrs[0] = 32'h6;   idx[0] = 32'd1;
    addrs[1] = 32'h80;  idx[1] = 32'd32;
    do_reset();
    for (int k = 0; k < 2; k++) begin
      req1_valid = 1'b1; req1_addr = addrs[k]; #1;
      tests++;
      if (req1_ready !== 1'b1) begin
        fails++; $display("FAIL err_ready k=%0d: rdy1=%b, required 1", k, req1_ready);
      end
      cyc(); req1_valid = 1'b0; #1;
      tests++;
      if (rom_addr !== idx[k]) begin
        fails++; $display("FAIL err_rom_addr k=%0d: got %0d, required %0d", k, rom_addr, idx[k]);
      end
      cyc(); #1;
      tests++;
      if (rsp1_valid !== 1'b1 || rsp1_err !== 1'b1 || rsp1_data !== 32'h0 || rsp0_valid !== 1'b0) begin
        fails++; $display("FAIL err_resp k=%0d: vld1=%b err=%b data=%h vld0=%b, required 1 1 0 0",
                          k, rsp1_valid, rsp1_err, rsp1_data, rsp0_valid);
      end
      cyc();
    end
  endtask

  task automatic test_reset_in_access();
    do_reset();
    req0_valid = 1'b1; req0_addr = 32'h8; #1;
    tests++;
    if (req0_ready !== 1'b1) begin
      fails++; $display("FAIL abort_accept: rdy0=%b, required 1", req0_ready);
    end
    cyc(); req0_valid = 1'b0;
    reset = 1'b0; req1_valid = 1'b1; req1_addr = 32'h4;
    for (int c = 0; c < 2; c++) begin
      #1;
      tests++;
      if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_err, rsp1_err} !== 6'b0 ||
          rsp0_data !== 32'h0 || rsp1_data !== 32'h0 || rom_addr !== 32'h0) begin
        fails++;
        $display("FAIL abort_held c=%0d: rdy=%b%b vld=%b%b err=%b%b d0=%h d1=%h rom_addr=%h, required all 0",
                 c, req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_err, rsp1_err, rsp0_data, rsp1_data, rom_addr);
      end
      cyc();
    end
    reset = 1'b1; #1;
    tests++;
    if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
      fails++; $display("FAIL abort_restart_ready: rdy1=%b rdy0=%b, required 1 0", req1_ready, req0_ready);
    end
    cyc(); req1_valid = 1'b0; #1;
    tests++;
    if (rom_addr !== 32'd1 || rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin
      fails++; $display("FAIL abort_restart_access: rom_addr=%0d vld=%b%b, required 1 00", rom_addr, rsp0_valid, rsp1_valid);
    end
    cyc(); #1;
    tests++;
    if (rsp1_valid !== 1'b1 || rsp1_data !== 32'h22221111 || rsp1_err !== 1'b0 || rsp0_valid !== 1'b0) begin
      fails++; $display("FAIL abort_restart_resp: vld1=%b data=%h err=%b vld0=%b, required 1 22221111 0 0",
                        rsp1_valid, rsp1_data, rsp1_err, rsp0_valid);
    end
    cyc();
  endtask

  initial begin
    tests = 0; fails = 0;
    for (int i = 0; i < 32; i++) rom[i] = 32'hA5000000 | i;
    rom[0] = 32'h11110000; rom[1] = 32'h22221111; rom[2] = 32'hDEADBEEF;
    test_reset();
    test_basic_read();
    test_back_to_back();
    test_addr_errors();
    test_reset_in_access();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
